uart_rx_frame: RTL and testbench

Serial receive stage that consumes the line driven by the UART transmitter's `TX_OUT`. It oversamples `RX_IN` by a programmable prescale and majority-votes three mid-bit samples per bit. It rebuilds start / 8 data (LSB first) / optional parity / stop frames and presents each good byte as `P_DATA` with a one-cycle `Data_Valid` pulse. It runs in the RX clock domain, sits directly downstream of the TX serial line, and feeds the system's RX data synchronizer.

---
 rtl/uart_rx_frame.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_rx_frame.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame.sv
// Purpose     : UART receive framer; oversamples RX_IN, 3-sample majority vote per bit,
//               rebuilds start / DATA_WIDTH data (LSB first) / optional parity / stop frames.
// Latency     : result pulses in cycle N*P + P/2 + 2 after the start edge (N = 9, or 10 with parity).
// Backpressure: none; the serial line cannot be stalled, so every result is a one-cycle pulse.
//
// Ports:
//   clk         receive oversampling clock (rising edge)
//   rst         asynchronous active-low reset
//   RX_IN       serial line, idle high, already synchronous to clk
//   Prescale    oversampling ratio (8, 16 or 32), captured at start detection
//   PAR_EN      parity bit present between data and stop, captured at start detection
//   PAR_TYP     0 = even, 1 = odd parity, captured at start detection
//   P_DATA      last good byte, held until the next good byte
//   Data_Valid  one-cycle pulse when P_DATA updates
//   Par_Err     one-cycle pulse at frame end on parity mismatch
//   Stp_Err     one-cycle pulse at frame end when the stop bit votes 0
//
// Build option: define UART_RX_START_CHECK_EN to reject a start bit that votes 1
// (line glitch) and return to IDLE without any output pulse.

module uart_rx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic [5:0]            Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  Par_Err,
    output logic                  Stp_Err
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

    logic [2:0]            state;
    logic [2:0]            state_d;
    logic [5:0]            edge_cnt;
    logic [3:0]            bit_cnt;
    logic [5:0]            pre_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic [1:0]            samp_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  par_bad_q;

    logic [5:0] half;
    logic       at_s0;
    logic       at_s1;
    logic       at_vote;
    logic       at_end;
    logic       vote;
    logic       exp_par;
    logic       start_det;

    // Sample points are taken from the prescale captured for this frame, so a
    // Prescale change on the port mid-frame cannot shift the sampling window.
    assign half    = {1'b0, pre_q[5:1]};
    assign at_s0   = (edge_cnt == half - 6'd1);
    assign at_s1   = (edge_cnt == half);
    assign at_vote = (edge_cnt == half + 6'd1);
    assign at_end  = (edge_cnt == pre_q - 6'd1);

    // Third sample is the live line at P/2+1, so the decision is available
    // in the same cycle and registered at its end.
    assign vote = (samp_q[0] & samp_q[1]) |
                  (samp_q[0] & RX_IN)     |
                  (samp_q[1] & RX_IN);

    // Expected parity bit: XOR of the data for even, inverted for odd.
    assign exp_par = (^shift_q) ^ par_typ_q;

    assign start_det = (state == IDLE) && !RX_IN;

    // ---------------------------------------------------------------- FSM
    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (!RX_IN) begin
                    state_d = START;
                end
            end
            START: begin
                if (at_end) begin
                    state_d = DATA;
                end
`ifdef UART_RX_START_CHECK_EN
                // A start bit that votes high was only a glitch on the line.
                if (at_vote && vote) begin
                    state_d = IDLE;
                end
`endif
            end
            DATA: begin
                if (at_end && (bit_cnt == LAST_BIT)) begin
                    state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (at_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                // Leave at the vote rather than the end of the stop bit so the
                // next start edge is never missed on back-to-back frames.
                if (at_vote) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // ---------------------------------------------------------- edge counter
    // The start-detect cycle is edge 0 of the start bit, hence the load of 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_cnt <= 6'd0;
        end else if (state == IDLE) begin
            edge_cnt <= RX_IN ? 6'd0 : 6'd1;
        end else if (state_d == IDLE || at_end) begin
            edge_cnt <= 6'd0;
        end else begin
            edge_cnt <= edge_cnt + 6'd1;
        end
    end

    // ----------------------------------------------------------- bit counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt <= 4'd0;
        end else if (state == START && at_end) begin
            bit_cnt <= 4'd0;
        end else if (state == DATA && at_end) begin
            bit_cnt <= (bit_cnt == LAST_BIT) ? 4'd0 : bit_cnt + 4'd1;
        end
    end

    // ------------------------------------------------ per-frame configuration
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q     <= 6'd0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
        end else if (start_det) begin
            pre_q     <= Prescale;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
        end
    end

    // ------------------------------------------------------- mid-bit samples
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            samp_q <= 2'b11;
        end else if (state != IDLE) begin
            if (at_s0) begin
                samp_q[0] <= RX_IN;
            end
            if (at_s1) begin
                samp_q[1] <= RX_IN;
            end
        end
    end

    // ------------------------------------------------ data and parity check
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q   <= '0;
            par_bad_q <= 1'b0;
        end else begin
            if (start_det) begin
                par_bad_q <= 1'b0;
            end
            if (state == DATA && at_vote) begin
                shift_q <= {vote, shift_q[DATA_WIDTH-1:1]};
            end
            if (state == PARITY && at_vote) begin
                par_bad_q <= (vote != exp_par);
            end
        end
    end

    // --------------------------------------------------------------- outputs
    // All pulses are registered; P_DATA only moves on a fully good frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            P_DATA     <= '0;
            Data_Valid <= 1'b0;
            Par_Err    <= 1'b0;
            Stp_Err    <= 1'b0;
        end else begin
            Data_Valid <= 1'b0;
            Par_Err    <= 1'b0;
            Stp_Err    <= 1'b0;
            if (state == STOP && at_vote) begin
                if (vote && !par_bad_q) begin
                    P_DATA     <= shift_q;
                    Data_Valid <= 1'b1;
                end
                Stp_Err <= !vote;
                Par_Err <= par_bad_q;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
`timescale 1ns/1ps

module tb_uart_rx_frame;

    logic       clk = 1'b0;
    logic       rst;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       Par_Err;
    logic       Stp_Err;

    uart_rx_frame #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .RX_IN      (RX_IN),
        .Prescale   (Prescale),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .Par_Err    (Par_Err),
        .Stp_Err    (Stp_Err)
    );

    always #5 clk = ~clk;

    // Cycle index: value of cyc during a clock period.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind = {Data_Valid, Par_Err, Stp_Err}
    typedef struct {
        logic [2:0] kind;
        logic [7:0] dat;
        int         when;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         n_chk  = 0;
    int         n_pass = 0;
    logic [7:0] last_good = 8'h00;

    task automatic check(input string tag, input longint obs, input longint req);
        n_chk++;
        if (obs == req) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, req, $time);
    endtask

    // Scoreboard: every output pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst && (Data_Valid || Par_Err || Stp_Err)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {Data_Valid, Par_Err, Stp_Err}, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("pulse_kind", {Data_Valid, Par_Err, Stp_Err}, mon_e.kind);
                check("p_data", P_DATA, mon_e.dat);
                check("pulse_cycle", cyc, mon_e.when);
                check("dv_se_together", Data_Valid & Stp_Err, 0);
            end
        end
    end

    // Hold the line at b for n cycles; entered and left at posedge+1.
    task automatic drive_bit(input logic b, input int n);
        RX_IN = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int p, input logic pen, input logic ptyp,
                              input logic [7:0] d, input logic bad_par,
                              input logic stop_bit);
        exp_t e;
        logic pbit;
        Prescale = 6'(p);
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        e.when = cyc + (pen ? 10 : 9) * p + p / 2 + 2;
        e.kind = {stop_bit && !(pen && bad_par), pen && bad_par, !stop_bit};
        if (e.kind[2]) last_good = d;
        e.dat = last_good;
        exp_q.push_back(e);
        drive_bit(1'b0, p);
        for (int i = 0; i < 8; i++) drive_bit(d[i], p);
        if (pen) begin
            pbit = (^d) ^ ptyp ^ bad_par;
            drive_bit(pbit, p);
        end
        if (stop_bit) begin
            drive_bit(1'b1, p);
        end else begin
            // Low only across the vote window so the receiver, back in IDLE
            // right after the vote, does not see a fresh start edge.
            drive_bit(1'b0, p / 2 + 2);
            drive_bit(1'b1, p - p / 2 - 2);
        end
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b0;
        RX_IN    = 1'b1;
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_p_data", P_DATA, 0);
        check("rst_data_valid", Data_Valid, 0);
        check("rst_par_err", Par_Err, 0);
        check("rst_stp_err", Stp_Err, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        idle(5);

        // Basic P=8 frame.
        send_frame(8, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1);
        idle(7);

        // P=16 odd parity, good then bad parity bit.
        send_frame(16, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b1);
        idle(9);
        send_frame(16, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b1);
        idle(9);

        // P=32 stop bit 0.
        send_frame(32, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0);
        idle(11);

        // Back-to-back at P=8.
        send_frame(8, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        send_frame(8, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1);
        send_frame(8, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1);
        idle(13);

        // Two-cycle low glitch.
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
`ifndef UART_RX_START_CHECK_EN
        // Without the start check the glitch runs a full frame of idle-high bits.
        mon_e.kind = 3'b100;
        mon_e.dat  = 8'hFF;
        mon_e.when = cyc + 78;
        last_good  = 8'hFF;
        exp_q.push_back(mon_e);
`endif
        drive_bit(1'b0, 2);
`ifdef UART_RX_START_CHECK_EN
        idle(18);
`else
        idle(100);
`endif
        send_frame(8, 1'b0, 1'b0, 8'h12, 1'b0, 1'b1);
        idle(6);

        // Reset at data bit 4 of a frame.
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        drive_bit(1'b0, 8);
        for (int i = 0; i < 4; i++) drive_bit(i[0], 8);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        last_good = 8'h00;
        check("midrst_p_data", P_DATA, 0);
        check("midrst_data_valid", Data_Valid, 0);
        check("midrst_par_err", Par_Err, 0);
        check("midrst_stp_err", Stp_Err, 0);
        RX_IN = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        idle(10);
        send_frame(8, 1'b0, 1'b0, 8'h7E, 1'b0, 1'b1);

        idle(50);
        check("pending_expectations", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
